// File: rtl/addsub_pipe_acc.sv
`default_nettype none
// ============================================================================
// Module  : addsub_pipe_acc
// Brief   : Pipelined signed add/sub/accumulate unit with valid/ready flow
//           control, overflow flag and optional saturation (negedge clocked).
// Revision: 1.0 - initial release
// ============================================================================
module addsub_pipe_acc #(
  parameter int WIDTH   = 16,
  parameter int LATENCY = 2,
  parameter int SAT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam logic [1:0]       c_OP_ADD  = 2'b00;
  localparam logic [1:0]       c_OP_SUB  = 2'b01;
  localparam logic [1:0]       c_OP_ACC  = 2'b10;
  localparam logic [1:0]       c_OP_LOAD = 2'b11;
  localparam logic [WIDTH-1:0] c_MAX     = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_MIN     = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]   r_acc;
  logic [LATENCY-1:0] r_vld;
  logic [LATENCY-1:0] r_ovf;
  logic [WIDTH-1:0]   r_res [LATENCY];

  logic [WIDTH:0]     w_ext_a;
  logic [WIDTH:0]     w_ext_b;
  logic [WIDTH:0]     w_ext_acc;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH-1:0]   w_res;
  logic               w_ovf;
  logic               w_accept;

  assign w_ext_a   = {a[WIDTH-1], a};
  assign w_ext_b   = {b[WIDTH-1], b};
  assign w_ext_acc = {r_acc[WIDTH-1], r_acc};

  // Arithmetic is one bit wider so the top two bits expose signed overflow.
  always_comb begin
    w_sum = w_ext_a;
    case (op)
      c_OP_ADD:  w_sum = w_ext_a + w_ext_b;
      c_OP_SUB:  w_sum = w_ext_a - w_ext_b;
      c_OP_ACC:  w_sum = w_ext_acc + w_ext_a;
      c_OP_LOAD: w_sum = w_ext_a;
      default:   w_sum = w_ext_a;
    endcase
    w_ovf = (op != c_OP_LOAD) && (w_sum[WIDTH] != w_sum[WIDTH-1]);
    w_res = w_sum[WIDTH-1:0];
    if ((SAT != 0) && w_ovf) begin
      w_res = w_sum[WIDTH] ? c_MIN : c_MAX;
    end
  end

  assign in_ready = ~out_valid | out_ready;
  assign w_accept = in_valid & in_ready;

  // ACC moves on the accept edge so chained ACC ops see the fresh value.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (w_accept && op[1]) begin
      r_acc <= w_res;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_vld <= '0;
      r_ovf <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_res[i] <= '0;
      end
    end else if (in_ready) begin
      r_vld[0] <= in_valid;
      if (in_valid) begin
        r_res[0] <= w_res;
        r_ovf[0] <= w_ovf;
      end
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_res[i] <= r_res[i-1];
        r_ovf[i] <= r_ovf[i-1];
      end
    end
  end

  assign out_valid = r_vld[LATENCY-1];
  assign result    = r_res[LATENCY-1];
  assign ovf       = r_ovf[LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_addsub_pipe_acc.sv
`default_nettype none
// ============================================================================
// Module  : tb_addsub_pipe_acc
// Brief   : Scoreboard bench driving a wrapping and a saturating instance.
// Revision: 1.0 - initial release
// ============================================================================
module tb_addsub_pipe_acc;

  typedef struct packed {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_ready;
  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [7:0] result0, result1;
  logic       ovf0, ovf1;

  int   checks   = 0;
  int   failures = 0;
  int   edges    = 0;
  int   stall_from = -100;
  bit   saw_full = 0;
  logic [7:0] acc0 = '0;
  logic [7:0] acc1 = '0;
  exp_t q0[$];
  exp_t q1[$];

  addsub_pipe_acc #(.WIDTH(8), .LATENCY(2), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
    .result(result0), .ovf(ovf0)
  );

  addsub_pipe_acc #(.WIDTH(8), .LATENCY(2), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .op(op), .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
    .result(result1), .ovf(ovf1)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer reference: exact signed value, then range-check and clamp.
  function automatic void model(input logic [1:0] mop, input logic [7:0] ma, input logic [7:0] mb,
                                input bit sat, input logic [7:0] acc_in,
                                output exp_t e, output logic [7:0] acc_out);
    int sa;
    int sb;
    int sacc;
    int r;
    sa   = $signed(ma);
    sb   = $signed(mb);
    sacc = $signed(acc_in);
    case (mop)
      2'b00:   r = sa + sb;
      2'b01:   r = sa - sb;
      2'b10:   r = sacc + sa;
      default: r = sa;
    endcase
    e.ovf = (r > 127) || (r < -128);
    if (e.ovf && sat) r = (r > 127) ? 127 : -128;
    e.res   = r[7:0];
    acc_out = mop[1] ? e.res : acc_in;
  endfunction

  task automatic tick(output bit accepted);
    exp_t e;
    exp_t got;
    logic [7:0] na;
    accepted  = 0;
    out_ready = !(edges >= stall_from && edges < stall_from + 5);
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
      acc0 = '0;
      acc1 = '0;
    end else begin
      if (!out_ready && out_valid0) begin
        saw_full = 1;
        chk("in_ready_full_wrap", in_ready0, 0);
        chk("in_ready_full_sat", in_ready1, 0);
      end
      if (out_valid0 && out_ready) begin
        chk("sb_wrap_pending", q0.size() != 0, 1);
        if (q0.size() != 0) begin
          got = q0.pop_front();
          chk("wrap_result", result0, got.res);
          chk("wrap_ovf", ovf0, got.ovf);
        end
      end
      if (out_valid1 && out_ready) begin
        chk("sb_sat_pending", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          got = q1.pop_front();
          chk("sat_result", result1, got.res);
          chk("sat_ovf", ovf1, got.ovf);
        end
      end
      if (in_valid && in_ready0) begin
        accepted = 1;
        model(op, a, b, 1'b0, acc0, e, na);
        acc0 = na;
        q0.push_back(e);
      end
      if (in_valid && in_ready1) begin
        model(op, a, b, 1'b1, acc1, e, na);
        acc1 = na;
        q1.push_back(e);
      end
    end
    @(negedge clk);
    #1;
    edges++;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic send(input logic [1:0] sop, input logic [7:0] sa, input logic [7:0] sb);
    bit acc;
    bit done;
    done     = 0;
    in_valid = 1'b1;
    op       = sop;
    a        = sa;
    b        = sb;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(acc);
      done = acc;
    end
    chk("send_accept_timeout", done, 1);
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op        = 2'b00;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_result", result0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_sat_out_valid", out_valid1, 0);

    // Single add: valid appears one edge after the accept edge, one cycle wide.
    send(2'b00, 8'h05, 8'h03);
    chk("t1_not_yet", out_valid0, 0);
    idle(1);
    chk("t1_valid", out_valid0, 1);
    chk("t1_result", result0, 8'h08);
    idle(1);
    chk("t1_one_wide", out_valid0, 0);

    // Negative overflow on subtract.
    send(2'b01, 8'h80, 8'h01);
    idle(3);

    // Chained accumulate, then a zero add reads ACC back.
    send(2'b11, 8'd10, 8'h00);
    send(2'b10, 8'd5, 8'h00);
    send(2'b10, 8'd5, 8'h00);
    send(2'b10, 8'd5, 8'h00);
    send(2'b10, 8'd0, 8'h00);
    idle(3);
    chk("t3_acc_model", acc0, 8'd25);

    // Stream with a five-edge sink stall in the middle.
    stall_from = edges + 2;
    send(2'b10, 8'd1, 8'h00);
    send(2'b00, 8'h40, 8'h41);
    send(2'b10, 8'd2, 8'h00);
    send(2'b01, 8'h10, 8'h30);
    send(2'b10, 8'd3, 8'h00);
    send(2'b10, 8'hF0, 8'h00);
    idle(4);
    chk("t4_in_ready_dropped", saw_full, 1);
    chk("t4_drained_wrap", q0.size(), 0);

    // Reset with ops in flight.
    send(2'b00, 8'h11, 8'h22);
    send(2'b10, 8'h07, 8'h00);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("t5_out_valid", out_valid0, 0);
    chk("t5_in_ready", in_ready0, 1);
    chk("t5_result", result0, 0);
    chk("t5_sat_out_valid", out_valid1, 0);
    send(2'b10, 8'h01, 8'h00);
    idle(3);

    // Saturating accumulate near the positive limit.
    send(2'b11, 8'h7F, 8'h00);
    send(2'b10, 8'h01, 8'h00);
    send(2'b10, 8'h01, 8'h00);
    idle(4);
    chk("t6_sat_acc", acc1, 8'h7F);
    chk("end_q_wrap", q0.size(), 0);
    chk("end_q_sat", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
